// File: rtl/rc_sync_master.sv
// Reconfiguration sync initiator: requests a region stop, waits for the
// acknowledge, then isolates/resets the region while streaming its bitstream.
module rc_sync_master #(
  parameter int unsigned C_TIMEOUT = 1024,
  parameter int unsigned C_RSTCNT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_req,
  input  logic [7:0]  sw_rrid,
  input  logic [31:0] sw_len,
  output logic        sw_busy,
  output logic        sw_done,
  output logic        sw_err,
  output logic        rc_reqn,
  input  logic        rc_ackn,
  output logic        rc_isolate,
  output logic        rc_rrst,
  output logic        cfg_rd,
  input  logic        cfg_rdy,
  output logic [7:0]  cfg_rrid
);

  localparam int unsigned LEN_W  = 32;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned TCNT_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam int unsigned RCNT_W = (C_RSTCNT > 1) ? $clog2(C_RSTCNT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(C_TIMEOUT - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(C_RSTCNT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_CFG  = 2'd2;
  localparam logic [1:0] ST_RST  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic [RCNT_W-1:0] rstcnt, rstcnt_nxt;
  logic [LEN_W-1:0]  wcnt, wcnt_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [ID_W-1:0]   rrid_nxt;
  logic              done_nxt, err_nxt;

  // Next-state, counter and pulse decode
  always_comb begin
    state_nxt  = state;
    tcnt_nxt   = tcnt;
    rstcnt_nxt = rstcnt;
    wcnt_nxt   = wcnt;
    len_nxt    = len_q;
    rrid_nxt   = cfg_rrid;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sw_req) begin
          state_nxt = ST_REQ;
          rrid_nxt  = sw_rrid;
          len_nxt   = sw_len;
          wcnt_nxt  = '0;
          tcnt_nxt  = '0;
        end
      end
      ST_REQ: begin
        tcnt_nxt = tcnt + TCNT_W'(1);
        // Acknowledge takes priority over a coincident timeout
        if (!rc_ackn) begin
          state_nxt  = (len_q != '0) ? ST_CFG : ST_RST;
          rstcnt_nxt = '0;
        end else if (tcnt == TCNT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      ST_CFG: begin
        if (cfg_rdy) begin
          wcnt_nxt = wcnt + LEN_W'(1);
          if (wcnt_nxt == len_q) begin
            state_nxt  = ST_RST;
            rstcnt_nxt = '0;
          end
        end
      end
      ST_RST: begin
        rstcnt_nxt = rstcnt + RCNT_W'(1);
        if (rstcnt == RCNT_LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tcnt       <= '0;
      rstcnt     <= '0;
      wcnt       <= '0;
      len_q      <= '0;
      cfg_rrid   <= '0;
      sw_busy    <= 1'b0;
      sw_done    <= 1'b0;
      sw_err     <= 1'b0;
      rc_reqn    <= 1'b1;
      rc_isolate <= 1'b0;
      rc_rrst    <= 1'b0;
      cfg_rd     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      rstcnt     <= rstcnt_nxt;
      wcnt       <= wcnt_nxt;
      len_q      <= len_nxt;
      cfg_rrid   <= rrid_nxt;
      sw_busy    <= (state_nxt != ST_IDLE);
      sw_done    <= done_nxt;
      sw_err     <= err_nxt;
      rc_reqn    <= (state_nxt != ST_REQ);
      rc_isolate <= (state_nxt == ST_CFG) || (state_nxt == ST_RST);
      rc_rrst    <= (state_nxt == ST_CFG) || (state_nxt == ST_RST);
      cfg_rd     <= (state_nxt == ST_CFG);
    end
  end

endmodule

// File: doc/rc_sync_master.md
# rc_sync_master

Initiator side of the reconfiguration synchronisation handshake. It sits in the reconfiguration controller, drives the active-low request toward a region's pipeline synchroniser and waits for its one-cycle active-low acknowledge. It then isolates and resets the region, streams a bitstream of a given word count to the configuration port, and reports completion or a timeout to the software-side request interface.

## Interface
- C_TIMEOUT, 1024: cycles allowed in REQ before an acknowledge; must be ≥ 1.
- C_RSTCNT, 16: cycles of region reset held after the last configuration word; must be ≥ 1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- sw_req  in  1  request pulse; accepted only in IDLE.
- sw_rrid  in  8  target module id; latched on accept.
- sw_len  in  32  bitstream length in words; latched on accept.
- sw_busy  out  1  high whenever state ≠ IDLE.
- sw_done  out  1  one-cycle pulse on successful completion.
- sw_err  out  1  one-cycle pulse on acknowledge timeout.
- rc_reqn  out  1  active-low synchronisation request.
- rc_ackn  in  1  active-low acknowledge, one-cycle pulse from the synchroniser.
- rc_isolate  out  1  decouples the region outputs.
- rc_rrst  out  1  region reset, active-high.
- cfg_rd  out  1  word request to the configuration port.
- cfg_rdy  in  1  word accepted when cfg_rd & cfg_rdy.
- cfg_rrid  out  8  latched module id; valid while sw_busy.

## Operation
- States: IDLE, REQ, CFG, RST. Outputs are decoded from the registered state. There are no combinational paths from inputs to rc_reqn, rc_isolate or rc_rrst.
- IDLE:
  - sw_req=1 moves to REQ.
  - Latch sw_rrid into cfg_rrid, sw_len into the length register, clear wcnt and tcnt.
  - sw_req outside IDLE is ignored; there is no queueing.
- REQ:
  - rc_reqn=0.
  - tcnt increments each cycle.
  - rc_ackn=0 moves to CFG if len≠0, or to RST if len=0; rstcnt clears.
  - tcnt==C_TIMEOUT-1 with rc_ackn=1 moves to IDLE and registers sw_err.
  - Acknowledge and timeout in the same cycle: the acknowledge wins.
- CFG:
  - rc_reqn=1, rc_isolate=1, rc_rrst=1, cfg_rd=1.
  - wcnt (32-bit) increments on cfg_rd & cfg_rdy.
  - Accepting the last word (wcnt+1==len and cfg_rdy) moves to RST and clears rstcnt.
  - cfg_rdy low stalls indefinitely; there is no timeout in CFG.
- RST:
  - rc_isolate=1, rc_rrst=1, cfg_rd=0.
  - rstcnt increments each cycle.
  - rstcnt==C_RSTCNT-1 moves to IDLE and registers sw_done.
- rc_ackn is ignored outside REQ.
- Counters compare with equality only. len=0xFFFFFFFF is legal and must not wrap early.
- Reset values: state=IDLE, rc_reqn=1, rc_isolate=0, rc_rrst=0, cfg_rd=0, sw_busy=0, sw_done=0, sw_err=0, cfg_rrid=0. All counters are 0.
- Reset asserted mid-operation (any state) returns to IDLE next edge with the reset values above. No sw_done or sw_err pulse is produced.

## Timing
- sw_req sampled at edge k: rc_reqn=0 and sw_busy=1 from cycle k+1.
- rc_ackn=0 sampled at edge m: rc_reqn=1 and rc_isolate=1 from cycle m+1. The synchroniser returns to its idle at the same edge and does not see a second request.
- cfg_rd is first high in cycle m+1, so the first word can be accepted at edge m+1.
- Last word at edge n: cfg_rd=0 from n+1, and RST lasts exactly C_RSTCNT cycles.
- sw_done is high in the first IDLE cycle after RST. sw_busy=0 in that same cycle.
- A new sw_req is accepted in that same cycle.
- Timeout: REQ lasts exactly C_TIMEOUT cycles. sw_err is high in the first IDLE cycle after REQ, and rc_reqn=1 in that cycle.

## Test plan
- Nominal:
  - Stimulus: sw_req with rrid=0x05, len=4; rc_ackn pulses low 10 cycles after rc_reqn falls; cfg_rdy=1.
  - Response: 4 words transferred; rc_rrst high for 4+16 cycles; sw_done single pulse; cfg_rrid=0x05; rc_reqn low exactly 10 cycles.
- Back-pressure:
  - Stimulus: len=3, cfg_rdy toggling 1,0,0,1,0,1.
  - Response: exactly 3 handshakes; RST entered the edge after the third; no extra cfg_rd.
- Timeout:
  - Stimulus: C_TIMEOUT=8; rc_ackn held high.
  - Response: rc_reqn low exactly 8 cycles; one sw_err pulse; rc_isolate never asserted.
- Boundaries:
  - Acknowledge on the final timeout cycle → CFG, no sw_err.
  - len=0 → straight to RST for 16 cycles, then sw_done.
  - sw_req pulses while busy → ignored.
- Reset mid-CFG:
  - Stimulus: assert rst after 2 of 4 words.
  - Response: next cycle rc_isolate=0, rc_rrst=0, cfg_rd=0, rc_reqn=1, no pulses.
  - A subsequent request completes normally.
- Back-to-back: sw_req asserted in the sw_done cycle → accepted; rc_reqn falls the next cycle.
